virtual_axi_full_mem: RTL and testbench

VIRTUAL_AXI_FULL_MEM -- requirements
Module: virtual_axi_full_mem

---
 rtl/virtual_axi_full_mem.sv | 230 +++++++++++++++++++++++
 tb/tb_virtual_axi_full_mem.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/virtual_axi_full_mem.sv
// AXI4 full slave memory model with a preloaded test-vector region.
module virtual_axi_full_mem #(
  parameter logic [1:0]  PAILLIER_MODE = 2'b00,
  parameter int unsigned TEST_TIMES    = 1,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned MEM_WORDS     = 1024
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  // write address
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam logic [1:0]  BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [IDX_W-1:0]      w_idx;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [1:0]            w_burst;
  logic                  w_fire;
  logic                  w_last_beat;

  r_state_t              r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_next_idx;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;

  // Storage. Words never written read back their preload pattern, which
  // gives the time-zero contents without an initialisation pass and keeps
  // everything (written flags included) independent of reset.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [MEM_WORDS-1:0]  written = '0;

  // Size fields are ignored and only the index bits of the addresses matter.
  logic unused_c;
  assign unused_c = ^{AWSIZE, ARSIZE, AWADDR, ARADDR};

  assign BRESP = 2'b00;
  assign RRESP = 2'b00;

  // Preload pattern: {mode, 32-bit word index} for the test-vector blocks.
  function automatic logic [DATA_WIDTH-1:0] preload(input logic [IDX_W-1:0] idx);
    logic [33:0] v;
    v = {PAILLIER_MODE, 32'(idx)};
    if (32'(idx) < 32'(4 * TEST_TIMES)) preload = DATA_WIDTH'(v);
    else                                preload = '0;
  endfunction

  // Current contents of a word.
  function automatic logic [DATA_WIDTH-1:0] word_at(input logic [IDX_W-1:0] idx);
    word_at = written[idx] ? mem[idx] : preload(idx);
  endfunction

  // FIXED bursts hold the index; INCR and WRAP step it, wrapping at MEM_WORDS.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [1:0] burst);
    next_idx = (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
  endfunction

  // Byte-lane merge of new write data over the old word.
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [STRB_W-1:0]     strb);
    merge = old_w;
    for (int unsigned b = 0; b < STRB_W; b++) begin
      if (strb[b]) merge[8*b +: 8] = new_w[8*b +: 8];
    end
  endfunction

  assign w_fire      = WREADY && WVALID;
  assign w_last_beat = WLAST || (w_cnt == w_len);
  assign r_next_idx  = next_idx(r_idx, r_burst);

  // Write channel FSM: address latch, data beats, single response.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
    if (M_AXI_ARESETN) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b0;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BID     <= '0;
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWREADY && AWVALID) begin
            w_id    <= AWID;
            w_idx   <= AWADDR[ADDR_LSB +: IDX_W];
            w_len   <= AWLEN;
            w_burst <= AWBURST;
            w_cnt   <= '0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= next_idx(w_idx, w_burst);
            w_cnt <= w_cnt + 8'd1;
            if (w_last_beat) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BID     <= w_id;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory array update on each accepted write beat.
  always_ff @(posedge M_AXI_ACLK) begin
    if (w_fire) begin
      mem[w_idx]     <= merge(word_at(w_idx), WDATA, WSTRB);
      written[w_idx] <= 1'b1;
    end
  end

  // Read channel FSM: address latch, then gap-free beats held under backpressure.
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
    if (M_AXI_ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RID     <= '0;
      RDATA   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARREADY && ARVALID) begin
            RID     <= ARID;
            r_idx   <= ARADDR[ADDR_LSB +: IDX_W];
            r_len   <= ARLEN;
            r_burst <= ARBURST;
            r_cnt   <= '0;
            RDATA   <= word_at(ARADDR[ADDR_LSB +: IDX_W]);
            RLAST   <= (ARLEN == 8'd0);
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            r_state <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RVALID && RREADY) begin
            if (RLAST) begin
              RVALID  <= 1'b0;
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_idx <= r_next_idx;
              RDATA <= word_at(r_next_idx);
              r_cnt <= r_cnt + 8'd1;
              RLAST <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_virtual_axi_full_mem.sv
// Scoreboard bench for virtual_axi_full_mem (mode 2, one test-vector block).
module tb_virtual_axi_full_mem;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 1024;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] AWID = '0;
  logic [AW-1:0] AWADDR = '0;
  logic [7:0]    AWLEN = '0;
  logic [2:0]    AWSIZE = '0;
  logic [1:0]    AWBURST = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [SW-1:0] WSTRB = '0;
  logic          WLAST = 1'b0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [IW-1:0] BID;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [IW-1:0] ARID = '0;
  logic [AW-1:0] ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic [2:0]    ARSIZE = '0;
  logic [1:0]    ARBURST = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [IW-1:0] RID;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model [MW];
  logic [DW-1:0] wbuf  [8];
  logic [DW-1:0] exp_rdata_q [$];
  logic [IW-1:0] exp_bid_q   [$];

  always #5 clk = ~clk;

  virtual_axi_full_mem #(
    .PAILLIER_MODE(2'd2), .TEST_TIMES(1), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_WORDS(MW)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] idx_of(input logic [AW-1:0] a);
    return a[13:4];
  endfunction

  function automatic logic [9:0] adv(input logic [9:0] idx, input logic [1:0] burst);
    return (burst == FIXED) ? idx : idx + 10'd1;
  endfunction

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                               input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = o;
    for (int j = 0; j < int'(SW); j++) if (s[j]) m[8*j +: 8] = d[8*j +: 8];
    return m;
  endfunction

  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd4; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin @(negedge clk); n++; end
    check("aw_wait", DW'(n < 50), DW'(1'b1));
    @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge clk); n++; end
    check("w_wait", DW'(n < 50), DW'(1'b1));
    @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_collect(input logic hold);
    int n = 0;
    if (hold) BREADY = 1'b0;
    while (!BVALID && n < 50) begin @(negedge clk); n++; end
    check("b_wait", DW'(n < 50), DW'(1'b1));
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check("bvalid_hold", DW'(BVALID), DW'(1'b1));
        check("awready_in_b", DW'(AWREADY), DW'(1'b0));
      end
      BREADY = 1'b1;
    end
    check("bid", DW'(BID), DW'(exp_bid_q.pop_front()));
    check("bresp", DW'(BRESP), DW'(2'b00));
    @(negedge clk);
    check("bvalid_clr", DW'(BVALID), DW'(1'b0));
    check("awready_back", DW'(AWREADY), DW'(1'b1));
  endtask

  // Full write transaction; the model takes the beats, the B id goes to the scoreboard.
  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats, input logic use_wlast,
                             input logic [SW-1:0] strb, input logic hold_b);
    logic [9:0] idx;
    idx = idx_of(addr);
    exp_bid_q.push_back(id);
    aw_send(id, addr, len, burst);
    for (int b = 0; b < nbeats; b++) begin
      model[idx] = apply_strb(model[idx], wbuf[b], strb);
      idx = adv(idx, burst);
      w_beat(wbuf[b], strb, use_wlast && (b == nbeats - 1));
    end
    b_collect(hold_b);
  endtask

  // Full read transaction; expected beats are pushed from the model at issue time.
  task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input int stall_beat, input int stall_n);
    logic [9:0]    idx;
    logic [DW-1:0] e;
    int n = 0;
    idx = idx_of(addr);
    for (int b = 0; b <= int'(len); b++) begin
      exp_rdata_q.push_back(model[idx]);
      idx = adv(idx, burst);
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd4; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin @(negedge clk); n++; end
    check("ar_wait", DW'(n < 50), DW'(1'b1));
    @(negedge clk);
    ARVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      e = exp_rdata_q.pop_front();
      check("rvalid", DW'(RVALID), DW'(1'b1));
      if (b == stall_beat) begin
        RREADY = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge clk);
          check("rvalid_stall", DW'(RVALID), DW'(1'b1));
          check("rdata_stall", RDATA, e);
          check("rlast_stall", DW'(RLAST), DW'(b == int'(len)));
        end
        RREADY = 1'b1;
      end
      check("rdata", RDATA, e);
      check("rlast", DW'(RLAST), DW'(b == int'(len)));
      check("rid", DW'(RID), DW'(id));
      check("rresp", DW'(RRESP), DW'(2'b00));
      @(negedge clk);
    end
    check("rvalid_end", DW'(RVALID), DW'(1'b0));
    check("arready_end", DW'(ARREADY), DW'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [9:0] i0;
    for (int i = 0; i < int'(MW); i++)
      model[i] = (i < 4) ? DW'({2'd2, 32'(i)}) : '0;

    // Reset: all outputs low while asserted, ready channels right after release
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_awready", DW'(AWREADY), '0);
    check("rst_wready",  DW'(WREADY),  '0);
    check("rst_bvalid",  DW'(BVALID),  '0);
    check("rst_arready", DW'(ARREADY), '0);
    check("rst_rvalid",  DW'(RVALID),  '0);
    check("rst_rlast",   DW'(RLAST),   '0);
    check("rst_ids",     DW'({BID, RID, BRESP, RRESP}), '0);
    check("rst_rdata",   RDATA, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready", DW'(AWREADY), DW'(1'b1));
    check("rel_arready", DW'(ARREADY), DW'(1'b1));

    // Preload pattern and an unloaded word
    check("preload_w3", model[3], DW'(34'h2_0000_0003));
    read_burst(4'd3, 64'h0, 8'd3, INCR, -1, 0);
    read_burst(4'd4, 64'd64, 8'd0, INCR, -1, 0);

    // Full-strobe write then readback
    wbuf[0] = {16{8'hA5}};
    wbuf[1] = {16{8'h5A}};
    write_burst(4'd5, 64'h40, 8'd1, INCR, 2, 1'b1, '1, 1'b0);
    read_burst(4'd9, 64'h40, 8'd1, INCR, -1, 0);

    // Single-byte strobe onto a zero word and onto a preloaded word
    wbuf[0] = '1;
    write_burst(4'd6, 64'h80, 8'd0, INCR, 1, 1'b1, 16'h0001, 1'b0);
    read_burst(4'd7, 64'h80, 8'd0, INCR, -1, 0);
    check("strb_word8", model[8], DW'(8'hFF));
    write_burst(4'd6, 64'h0, 8'd0, INCR, 1, 1'b1, 16'h0001, 1'b0);
    read_burst(4'd7, 64'h0, 8'd0, INCR, -1, 0);

    // Backpressure on R mid-burst and on B
    read_burst(4'd2, 64'h0, 8'd3, INCR, 1, 5);
    read_burst(4'd2, 64'h0, 8'd3, INCR, 3, 5);
    for (int k = 0; k < 3; k++) wbuf[k] = {$urandom, $urandom, $urandom, $urandom};
    write_burst(4'd1, 64'h300, 8'd2, INCR, 3, 1'b1, '1, 1'b1);
    read_burst(4'd1, 64'h300, 8'd2, INCR, -1, 0);

    // Address alias: MEM_WORDS*16 lands on word 0
    wbuf[0] = {4{32'hCAFE_F00D}};
    write_burst(4'd2, 64'(MW * 16), 8'd0, INCR, 1, 1'b1, '1, 1'b0);
    check("alias_model", model[0], {4{32'hCAFE_F00D}});
    read_burst(4'd3, 64'h0, 8'd0, INCR, -1, 0);

    // FIXED write burst of four: only the last beat stays, neighbours untouched
    for (int k = 0; k < 4; k++) wbuf[k] = DW'(32'h1000 + k);
    write_burst(4'd4, 64'h100, 8'd3, FIXED, 4, 1'b1, '1, 1'b0);
    i0 = idx_of(64'h100);
    check("fixed_model", model[i0], DW'(32'h1003));
    read_burst(4'd4, 64'h100, 8'd3, INCR, -1, 0);
    read_burst(4'd5, 64'h100, 8'd2, FIXED, -1, 0);

    // Burst ends on beat count without WLAST, and early on WLAST
    for (int k = 0; k < 4; k++) wbuf[k] = DW'(32'h2000 + k);
    write_burst(4'd5, 64'h500, 8'd2, INCR, 3, 1'b0, '1, 1'b0);
    read_burst(4'd5, 64'h500, 8'd3, INCR, -1, 0);
    write_burst(4'd6, 64'h600, 8'd3, INCR, 2, 1'b1, '1, 1'b0);
    read_burst(4'd6, 64'h600, 8'd3, INCR, -1, 0);

    // WRAP steps like INCR and wraps around the top of memory
    wbuf[0] = DW'(32'h3000); wbuf[1] = DW'(32'h3001);
    write_burst(4'd7, 64'h3FF0, 8'd1, WRAP, 2, 1'b1, '1, 1'b0);
    read_burst(4'd8, 64'h3FF0, 8'd1, INCR, -1, 0);

    // Reset mid-burst: accepted beats persist, the rest of the burst is dropped
    aw_send(4'd7, 64'h700, 8'd3, INCR);
    for (int k = 0; k < 2; k++) begin
      wbuf[k] = DW'(32'h4000 + k);
      model[idx_of(64'h700) + 10'(k)] = wbuf[k];
      w_beat(wbuf[k], '1, 1'b0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_wready", DW'(WREADY), '0);
    check("abort_bvalid", DW'(BVALID), '0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_awready", DW'(AWREADY), DW'(1'b1));
    read_burst(4'd1, 64'h700, 8'd3, INCR, -1, 0);
    read_burst(4'd2, 64'h0, 8'd3, INCR, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
